// File: rtl/matrix_mac_pkg.sv
// -----------------------------------------------------------------------------
// matrix_mac_pkg
//   Shared definitions for the parametrised matrix MAC engine: FSM state
//   encoding, default geometry constants and the k-counter width helper.
//   Optional feature macro used by the engine: MATRIX_MAC_SATURATE_EN.
// -----------------------------------------------------------------------------
package matrix_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DIM_DEF        = 4;
  localparam int ACC_WIDTH_DEF  = 24;
  localparam int K_WIDTH_DEF    = $clog2(DIM_DEF);

  // Width of the inner-product index counter for a given dimension.
  function automatic int k_width(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/matrix_mac_engine_mac_cell.sv
// -----------------------------------------------------------------------------
// mac_cell
//   One accumulator element of the MAC array: signed multiply, sign-extend,
//   add onto the accumulator (or onto zero), optional saturation.
//   Saturation and the local overflow output exist only when
//   MATRIX_MAC_SATURATE_EN is defined; otherwise adds wrap.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-low reset
//   step_i            perform one multiply-accumulate this edge
//   zero_base_i       use 0 instead of the accumulator as the addend
//   clear_i           zero the accumulator (priority over step_i)
//   a_i, b_i          signed operand elements
//   acc_o             accumulator value
//   ovf_o             this edge's update clamps (saturating build only)
// -----------------------------------------------------------------------------
module mac_cell
  import matrix_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  step_i,
  input  logic                  zero_base_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]  acc_o
`ifdef MATRIX_MAC_SATURATE_EN
  ,
  output logic                  ovf_o
`endif
);

  logic [ACC_WIDTH-1:0]          acc_q;
  logic [ACC_WIDTH-1:0]          acc_d;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]          base;

  assign prod     = $signed(a_i) * $signed(b_i);
  assign prod_ext = ACC_WIDTH'(prod);
  assign base     = zero_base_i ? '0 : acc_q;

`ifdef MATRIX_MAC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // One guard bit: overflow shows up as the top two bits disagreeing.
  logic [ACC_WIDTH:0] sum_wide;
  logic               sat_hi;
  logic               sat_lo;

  assign sum_wide = {base[ACC_WIDTH-1], base} + {prod_ext[ACC_WIDTH-1], prod_ext};
  assign sat_hi   = !sum_wide[ACC_WIDTH] &&  sum_wide[ACC_WIDTH-1];
  assign sat_lo   =  sum_wide[ACC_WIDTH] && !sum_wide[ACC_WIDTH-1];
  assign acc_d    = sat_hi ? ACC_MAX : (sat_lo ? ACC_MIN : sum_wide[ACC_WIDTH-1:0]);
  assign ovf_o    = step_i && (sat_hi || sat_lo);
`else
  assign acc_d = base + prod_ext;
`endif

  // NOTE: accumulators are plain flops, not a RAM, so they take the reset;
  // sequential state is always written with non-blocking assignments.
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (step_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/matrix_mac_engine.sv
// -----------------------------------------------------------------------------
// matrix_mac_engine
//   Computes C = A*B or C = C + A*B for DIM x DIM signed matrices using a
//   DIM x DIM array of mac_cell, one inner-product index k per enabled RUN
//   cycle. start/busy/done handshake, per-operation accumulate mode, stall
//   via enable, abort via clear.
//   Optional macro MATRIX_MAC_SATURATE_EN: saturating adds plus a sticky
//   overflow flag; without it adds wrap and overflow is tied low.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-low reset
//   enable                advance permission while in RUN
//   clear                 zero accumulators, abort, return to IDLE
//   start, accumulate     begin an operation (IDLE only) and its mode
//   matrix_1, matrix_2    operands A and B, row-major packed
//   busy, done            high in RUN/DONE; one-cycle completion pulse
//   overflow              sticky saturation flag
//   result                accumulator array, row-major packed
// -----------------------------------------------------------------------------
module matrix_mac_engine
  import matrix_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DIM        = DIM_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              clear,
  input  logic                              start,
  input  logic                              accumulate,
  input  logic [DIM*DIM*DATA_WIDTH-1:0]     matrix_1,
  input  logic [DIM*DIM*DATA_WIDTH-1:0]     matrix_2,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow,
  output logic [DIM*DIM*ACC_WIDTH-1:0]      result
);

  localparam int             KW     = k_width(DIM);
  localparam logic [KW-1:0]  K_LAST = KW'(DIM - 1);

  state_e                          state_q;
  logic [KW-1:0]                   k_q;
  logic [DIM*DIM*DATA_WIDTH-1:0]   op_a_q;
  logic [DIM*DIM*DATA_WIDTH-1:0]   op_b_q;
  logic                            mode_q;   // 1 = accumulate onto result
  logic                            busy_q;
  logic                            done_q;

  // Control FSM with registered busy/done.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_a_q  <= matrix_1;
            op_b_q  <= matrix_2;
            mode_q  <= accumulate;
            k_q     <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (enable) begin
            if (k_q == K_LAST) begin
              k_q     <= '0;
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          k_q     <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // Cell controls: update only on an enabled RUN edge that is not a clear;
  // overwrite mode replaces the old value on the first (k=0) update.
  logic step;
  logic zero_base;

  assign step      = (state_q == RUN) && enable && !clear;
  assign zero_base = !mode_q && (k_q == '0);

  // Column k of A feeds row i; row k of B feeds column j.
  logic [DATA_WIDTH-1:0] a_sel [DIM];
  logic [DATA_WIDTH-1:0] b_sel [DIM];

  for (genvar n = 0; n < DIM; n++) begin : g_sel
    assign a_sel[n] = op_a_q[(n*DIM + int'(k_q))*DATA_WIDTH +: DATA_WIDTH];
    assign b_sel[n] = op_b_q[(int'(k_q)*DIM + n)*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef MATRIX_MAC_SATURATE_EN
  logic [DIM*DIM-1:0] cell_ovf;
`endif

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      mac_cell #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_cell (
        .clock       (clock),
        .reset       (reset),
        .step_i      (step),
        .zero_base_i (zero_base),
        .clear_i     (clear),
        .a_i         (a_sel[i]),
        .b_i         (b_sel[j]),
        .acc_o       (result[(i*DIM + j)*ACC_WIDTH +: ACC_WIDTH])
`ifdef MATRIX_MAC_SATURATE_EN
        ,
        .ovf_o       (cell_ovf[i*DIM + j])
`endif
      );
    end
  end

`ifdef MATRIX_MAC_SATURATE_EN
  // Sticky until reset, clear, or a new overwrite operation is accepted.
  logic overflow_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (clear) begin
      overflow_q <= 1'b0;
    end else if ((state_q == IDLE) && start && !accumulate) begin
      overflow_q <= 1'b0;
    end else if (|cell_ovf) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_mac_engine.sv
// -----------------------------------------------------------------------------
// tb_matrix_mac_engine
//   Directed bench for matrix_mac_engine. Two instances share all inputs:
//   u_dut0 with default parameters and u_dut1 with ACC_WIDTH=16 for the
//   saturation/wrap case. Inputs change and outputs are sampled on the
//   falling clock edge. Build with or without MATRIX_MAC_SATURATE_EN.
// -----------------------------------------------------------------------------
module tb_matrix_mac_engine;

  localparam int DW  = 8;
  localparam int DIM = 4;
  localparam int AW0 = 24;
  localparam int AW1 = 16;

  logic clock      = 1'b0;
  logic reset      = 1'b0;
  logic enable     = 1'b1;
  logic clear      = 1'b0;
  logic start      = 1'b0;
  logic accumulate = 1'b0;
  logic [DIM*DIM*DW-1:0] matrix_1 = '0;
  logic [DIM*DIM*DW-1:0] matrix_2 = '0;

  logic busy0, done0, ovf0;
  logic busy1, done1, ovf1;
  logic [DIM*DIM*AW0-1:0] result0;
  logic [DIM*DIM*AW1-1:0] result1;

  int a_m [DIM][DIM];
  int b_m [DIM][DIM];
  int n_checks = 0;
  int n_fail   = 0;
  int lat, busy_n, done_n;

  always #5 clock = ~clock;

  matrix_mac_engine #(.DATA_WIDTH(DW), .DIM(DIM), .ACC_WIDTH(AW0)) u_dut0 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .start(start), .accumulate(accumulate),
    .matrix_1(matrix_1), .matrix_2(matrix_2),
    .busy(busy0), .done(done0), .overflow(ovf0), .result(result0)
  );

  matrix_mac_engine #(.DATA_WIDTH(DW), .DIM(DIM), .ACC_WIDTH(AW1)) u_dut1 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .start(start), .accumulate(accumulate),
    .matrix_1(matrix_1), .matrix_2(matrix_2),
    .busy(busy1), .done(done1), .overflow(ovf1), .result(result1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  function automatic logic signed [AW0-1:0] r0(input int i, input int j);
    return result0[(i*DIM + j)*AW0 +: AW0];
  endfunction

  function automatic logic signed [AW1-1:0] r1(input int i, input int j);
    return result1[(i*DIM + j)*AW1 +: AW1];
  endfunction

  // Reference: sum over the first kn inner-product terms of A*B.
  function automatic int model(input int i, input int j, input int kn);
    int s = 0;
    for (int k = 0; k < kn; k++) s += a_m[i][k] * b_m[k][j];
    return s;
  endfunction

  task automatic check_all0(input string tag, input int add, input int kn);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        check($sformatf("%s[%0d][%0d]", tag, i, j), 32'(r0(i, j)), add + model(i, j, kn));
  endtask

  task automatic check_all1(input string tag, input int exp);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        check($sformatf("%s[%0d][%0d]", tag, i, j), 32'(r1(i, j)), exp);
  endtask

  task automatic load_operands();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        matrix_1[(i*DIM + j)*DW +: DW] = DW'(a_m[i][j]);
        matrix_2[(i*DIM + j)*DW +: DW] = DW'(b_m[i][j]);
      end
  endtask

  // Pulse start across one rising edge (E0), then scramble the operand
  // inputs so the result depends on the captured copies only.
  task automatic start_op(input logic acc_mode);
    accumulate = acc_mode;
    start      = 1'b1;
    @(negedge clock);
    start      = 1'b0;
    matrix_1   = ~matrix_1;
    matrix_2   = ~matrix_2;
  endtask

  // Advance until done0 is seen (bounded). lat is the cycle index after
  // E0 (cycle 1 is the one right after E0); busy_n counts busy cycles
  // from lat0 through the done cycle inclusive.
  task automatic wait_done(input int lat0, output int lat_o, output int busy_o);
    lat_o  = lat0;
    busy_o = 0;
    while (done0 !== 1'b1 && lat_o < 40) begin
      if (busy0 === 1'b1) busy_o++;
      @(negedge clock);
      lat_o++;
    end
    if (busy0 === 1'b1) busy_o++;
  endtask

  task automatic watch_no_done(output int seen);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (done0 === 1'b1 || busy0 === 1'b1) seen++;
    end
  endtask

  initial begin
    // Reset
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_ovf", 32'(ovf0), 0);
    check("rst_ovf1", 32'(ovf1), 0);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        a_m[i][j] = 0;
        b_m[i][j] = 0;
      end
    check_all0("rst_res", 0, 0);

    // Identity times all-3, overwrite
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        a_m[i][j] = (i == j) ? 1 : 0;
        b_m[i][j] = 3;
      end
    load_operands();
    start_op(1'b0);
    wait_done(1, lat, busy_n);
    check("ident_latency", 32'(lat), 5);
    check("ident_busy_cycles", 32'(busy_n), 5);
    check_all0("ident", 0, 4);
    check_all1("ident_w16", 3);
    // start during the done cycle must be ignored
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("ident_post_busy", 32'(busy0), 0);
    check("ident_post_done", 32'(done0), 0);
    @(negedge clock);
    check("ident_no_requeue", 32'(busy0), 0);
    check("ident_hold", 32'(r0(2, 1)), 3);

    // Accumulate onto previous result
    load_operands();
    start_op(1'b1);
    wait_done(1, lat, busy_n);
    check("accum_latency", 32'(lat), 5);
    check_all0("accum", 3, 4);
    @(negedge clock);

    // Overwrite again
    load_operands();
    start_op(1'b0);
    wait_done(1, lat, busy_n);
    check_all0("overwrite", 0, 4);
    @(negedge clock);

    // Identity times a distinct B: result must equal B (orientation check)
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) b_m[i][j] = i*DIM + j - 5;
    load_operands();
    start_op(1'b0);
    wait_done(1, lat, busy_n);
    check_all0("ident_b", 0, 4);
    @(negedge clock);

    // Signed extremes: all -128, each element 4*16384 = 65536
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        a_m[i][j] = -128;
        b_m[i][j] = -128;
      end
    load_operands();
    start_op(1'b0);
    wait_done(1, lat, busy_n);
    check_all0("extreme", 0, 4);
    check("extreme_ovf", 32'(ovf0), 0);
    @(negedge clock);

    // All 127: 4*16129 = 64516; 16-bit instance wraps to -1020 or clamps
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        a_m[i][j] = 127;
        b_m[i][j] = 127;
      end
    load_operands();
    start_op(1'b0);
    wait_done(1, lat, busy_n);
    check_all0("sat_w24", 0, 4);
    check("sat_w24_ovf", 32'(ovf0), 0);
`ifdef MATRIX_MAC_SATURATE_EN
    check_all1("sat_w16", 32767);
    check("sat_w16_ovf", 32'(ovf1), 1);
    @(negedge clock);
    check("sat_w16_ovf_sticky", 32'(ovf1), 1);
`else
    check_all1("wrap_w16", -1020);
    check("wrap_w16_ovf", 32'(ovf1), 0);
    @(negedge clock);
`endif

    // Stall: A(i,j)=i*4+j-8, B=2I, enable low for E3..E5
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        a_m[i][j] = i*DIM + j - 8;
        b_m[i][j] = (i == j) ? 2 : 0;
      end
    load_operands();
    start_op(1'b0);
    check("stall_ovf_cleared", 32'(ovf1), 0);
    @(negedge clock);
    @(negedge clock);
    enable = 1'b0;
    check_all0("stall_partial", 0, 2);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("stall_busy", 32'(busy0), 1);
    check("stall_done", 32'(done0), 0);
    check_all0("stall_hold", 0, 2);
    enable = 1'b1;
    wait_done(6, lat, busy_n);
    check("stall_latency", 32'(lat), 8);
    check_all0("stall_final", 0, 4);
    @(negedge clock);
    check("stall_start_ignored", 32'(busy0), 0);

    // clear has priority over start in IDLE
    clear = 1'b1;
    start = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    start = 1'b0;
    check("clr_prio_busy", 32'(busy0), 0);
    check_all0("clr_prio_res", 0, 0);

    // Abort via clear after the second RUN edge
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        a_m[i][j] = (i == j) ? 1 : 0;
        b_m[i][j] = 3;
      end
    load_operands();
    start_op(1'b0);
    @(negedge clock);
    @(negedge clock);
    check_all0("abort_partial", 0, 2);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("abort_clr_busy", 32'(busy0), 0);
    check("abort_clr_ovf", 32'(ovf0), 0);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) b_m[i][j] = 0;
    check_all0("abort_clr_res", 0, 0);
    watch_no_done(done_n);
    check("abort_clr_no_done", 32'(done_n), 0);

    // Abort via reset after the second RUN edge
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) b_m[i][j] = 3;
    load_operands();
    start_op(1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("abort_rst_busy", 32'(busy0), 0);
    check("abort_rst_done", 32'(done0), 0);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) b_m[i][j] = 0;
    check_all0("abort_rst_res", 0, 0);
    watch_no_done(done_n);
    check("abort_rst_no_done", 32'(done_n), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
